morse_input_scheduler: RTL and testbench



---
 rtl/morse_input_scheduler.sv | 268 ++++++++++++++++++++++++++
 tb/tb_morse_input_scheduler.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/morse_input_scheduler.sv
// morse_input_scheduler
//   Merges the telegraph button and the 4x4 keypad into the single
//   key/flag/backspace stream consumed by decoder_controller. Telegraph presses
//   are synchronised and debounced, then timed and classified as dot (4'hf) or
//   dash (4'he). A letter auto-commits (4'hd) after an inter-letter gap. One
//   source owns the decoder for the length of a letter.
//
// Handshake: kp_valid is a one-cycle strobe qualifying kp_key and is taken in
//   the cycle it is high. kp_ready is high when en is set and the keypad slot is
//   empty. A strobe that cannot be stored, or that comes from the non-owning
//   source, is dropped and overrun pulses for one cycle. No request is held
//   waiting on kp_ready.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   en         block enable; low flushes everything to idle synchronously
//   tele_key   raw telegraph button, active-high, asynchronous
//   kp_key     keypad code: 4'he dash, 4'hf dot, 4'hd commit, others ignored
//   kp_valid   one-cycle strobe qualifying kp_key
//   kp_bs      one-cycle backspace request
//   kp_ready   en and keypad slot empty (combinational)
//   key        code presented to the decoder
//   flag       symbol strobe, high for FLAG_HOLD cycles
//   backspace  backspace strobe, high for FLAG_HOLD cycles
//   owner      00 none, 01 keypad, 10 telegraph
//   overrun    one-cycle pulse when a request is dropped
module morse_input_scheduler #(
  parameter int DEBOUNCE_TICKS = 1_000_000,
  parameter int DASH_TICKS     = 30_000_000,
  parameter int GAP_TICKS      = 70_000_000,
  parameter int FLAG_HOLD      = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       tele_key,
  input  logic [3:0] kp_key,
  input  logic       kp_valid,
  input  logic       kp_bs,
  output logic       kp_ready,
  output logic [3:0] key,
  output logic       flag,
  output logic       backspace,
  output logic [1:0] owner,
  output logic       overrun
);

  localparam int DW   = $clog2(DEBOUNCE_TICKS + 1);
  localparam int TMAX = (DASH_TICKS > GAP_TICKS) ? DASH_TICKS : GAP_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int HW   = $clog2(FLAG_HOLD + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [TW-1:0] DASH_T    = TW'(DASH_TICKS);
  localparam logic [TW-1:0] GAP_T     = TW'(GAP_TICKS);
  localparam logic [HW-1:0] HOLD_LAST = HW'(FLAG_HOLD - 1);

  localparam logic [3:0] KEY_DASH   = 4'he;
  localparam logic [3:0] KEY_DOT    = 4'hf;
  localparam logic [3:0] KEY_COMMIT = 4'hd;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_KP   = 2'b01;
  localparam logic [1:0] OWN_TELE = 2'b10;

  typedef enum logic [1:0] {T_IDLE, T_PRESS, T_GAP} tele_state_t;
  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} seq_state_t;

  // Telegraph front end
  logic          sync1, sync2, tele_db;
  logic [DW-1:0] db_cnt;

  // Telegraph FSM
  tele_state_t   t_state, t_state_d;
  logic [TW-1:0] t_cnt, t_cnt_d;
  logic          t_emit;
  logic [3:0]    t_emit_key;

  // Request slots
  logic       t_slot_v, k_slot_v, bs_pend;
  logic [3:0] t_slot_key, k_slot_key;

  // Output sequencer
  seq_state_t    s_state, s_state_d;
  logic [HW-1:0] s_cnt, s_cnt_d;
  logic          s_bs, s_commit;
  logic          grant_t, grant_k, grant_bs, drop_t, drop_k;
  logic [3:0]    grant_key;
  logic          seq_done;

  // Capture decisions
  logic kp_req, kp_take, kp_drop, t_take, t_drop, bs_drop;

  always_comb begin
    t_state_d  = t_state;
    t_cnt_d    = t_cnt;
    t_emit     = 1'b0;
    t_emit_key = KEY_DOT;
    case (t_state)
      T_IDLE: begin
        if (tele_db) begin
          t_state_d = T_PRESS;
          t_cnt_d   = '0;
        end
      end
      T_PRESS: begin
        if (!tele_db) begin
          t_emit     = 1'b1;
          t_emit_key = (t_cnt >= DASH_T) ? KEY_DASH : KEY_DOT;
          t_state_d  = T_GAP;
          t_cnt_d    = '0;
        end else if (t_cnt < DASH_T) begin
          t_cnt_d = t_cnt + TW'(1);
        end
      end
      T_GAP: begin
        if (tele_db) begin
          t_state_d = T_PRESS;
          t_cnt_d   = '0;
        end else if (t_cnt == GAP_T) begin
          t_emit     = 1'b1;
          t_emit_key = KEY_COMMIT;
          t_state_d  = T_IDLE;
          t_cnt_d    = '0;
        end else begin
          t_cnt_d = t_cnt + TW'(1);
        end
      end
      default: begin
        t_state_d = T_IDLE;
        t_cnt_d   = '0;
      end
    endcase
  end

  // Arbiter and sequencer. Backspace goes first, then telegraph, then keypad.
  // A slot whose source lost ownership after it was captured is discarded here.
  always_comb begin
    s_state_d = s_state;
    s_cnt_d   = s_cnt;
    grant_t   = 1'b0;
    grant_k   = 1'b0;
    grant_bs  = 1'b0;
    drop_t    = 1'b0;
    drop_k    = 1'b0;
    case (s_state)
      S_IDLE: begin
        if (bs_pend)              grant_bs = 1'b1;
        else if (t_slot_v) begin
          if (owner != OWN_KP)    grant_t  = 1'b1;
          else                    drop_t   = 1'b1;
        end else if (k_slot_v) begin
          if (owner != OWN_TELE)  grant_k  = 1'b1;
          else                    drop_k   = 1'b1;
        end
        if (grant_bs || grant_t || grant_k) begin
          s_state_d = S_HIGH;
          s_cnt_d   = '0;
        end
      end
      S_HIGH: begin
        if (s_cnt == HOLD_LAST) begin
          s_state_d = S_LOW;
          s_cnt_d   = '0;
        end else begin
          s_cnt_d = s_cnt + HW'(1);
        end
      end
      S_LOW: begin
        if (s_cnt == HOLD_LAST) begin
          s_state_d = S_IDLE;
          s_cnt_d   = '0;
        end else begin
          s_cnt_d = s_cnt + HW'(1);
        end
      end
      default: begin
        s_state_d = S_IDLE;
        s_cnt_d   = '0;
      end
    endcase
  end

  assign grant_key = grant_t ? t_slot_key : k_slot_key;
  assign seq_done  = (s_state == S_LOW) && (s_cnt == HOLD_LAST);

  assign kp_req  = kp_valid && (kp_key == KEY_DASH || kp_key == KEY_DOT || kp_key == KEY_COMMIT);
  assign kp_take = kp_req && !k_slot_v && (owner != OWN_TELE);
  assign kp_drop = kp_req && !kp_take;
  assign t_take  = t_emit && !t_slot_v && (owner != OWN_KP);
  assign t_drop  = t_emit && !t_take;
  assign bs_drop = kp_bs && bs_pend && !grant_bs;

  assign kp_ready  = en && !k_slot_v;
  assign flag      = (s_state == S_HIGH) && !s_bs;
  assign backspace = (s_state == S_HIGH) && s_bs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;  sync2 <= 1'b0;  tele_db <= 1'b0;  db_cnt <= '0;
      t_state <= T_IDLE;  t_cnt <= '0;
      t_slot_v <= 1'b0;  t_slot_key <= '0;
      k_slot_v <= 1'b0;  k_slot_key <= '0;  bs_pend <= 1'b0;
      s_state <= S_IDLE;  s_cnt <= '0;  s_bs <= 1'b0;  s_commit <= 1'b0;
      key <= '0;  owner <= OWN_NONE;  overrun <= 1'b0;
    end else if (!en) begin
      sync1 <= 1'b0;  sync2 <= 1'b0;  tele_db <= 1'b0;  db_cnt <= '0;
      t_state <= T_IDLE;  t_cnt <= '0;
      t_slot_v <= 1'b0;  t_slot_key <= '0;
      k_slot_v <= 1'b0;  k_slot_key <= '0;  bs_pend <= 1'b0;
      s_state <= S_IDLE;  s_cnt <= '0;  s_bs <= 1'b0;  s_commit <= 1'b0;
      key <= '0;  owner <= OWN_NONE;  overrun <= 1'b0;
    end else begin
      sync1 <= tele_key;
      sync2 <= sync1;
      // Accepted level flips only after DEBOUNCE_TICKS consecutive differing samples.
      if (sync2 == tele_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        tele_db <= sync2;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + DW'(1);
      end

      t_state <= t_state_d;
      t_cnt   <= t_cnt_d;
      s_state <= s_state_d;
      s_cnt   <= s_cnt_d;

      if (grant_t || drop_t) t_slot_v <= 1'b0;
      if (t_take) begin
        t_slot_v   <= 1'b1;
        t_slot_key <= t_emit_key;
      end
      if (grant_k || drop_k) k_slot_v <= 1'b0;
      if (kp_take) begin
        k_slot_v   <= 1'b1;
        k_slot_key <= kp_key;
      end
      if (grant_bs) bs_pend <= 1'b0;
      if (kp_bs && !bs_drop) bs_pend <= 1'b1;

      // Backspace leaves key untouched so the decoder sees only the strobe.
      if (grant_t || grant_k) begin
        key      <= grant_key;
        s_bs     <= 1'b0;
        s_commit <= (grant_key == KEY_COMMIT);
      end
      if (grant_bs) begin
        s_bs     <= 1'b1;
        s_commit <= 1'b0;
      end

      // Ownership is released only once the commit strobe has fully completed.
      if (seq_done && s_commit) begin
        owner <= OWN_NONE;
      end else if (owner == OWN_NONE && grant_key != KEY_COMMIT) begin
        if (grant_t)      owner <= OWN_TELE;
        else if (grant_k) owner <= OWN_KP;
      end

      overrun <= kp_drop || t_drop || bs_drop || drop_t || drop_k;
    end
  end

endmodule

// File: tb/tb_morse_input_scheduler.sv
module tb_morse_input_scheduler;

  localparam int DEB  = 2;
  localparam int DASH = 20;
  localparam int GAP  = 50;
  localparam int FH   = 3;

  logic       clk, rst_n, en, tele_key, kp_valid, kp_bs;
  logic [3:0] kp_key;
  logic       kp_ready, flag, backspace, overrun;
  logic [3:0] key;
  logic [1:0] owner;

  morse_input_scheduler #(
    .DEBOUNCE_TICKS(DEB), .DASH_TICKS(DASH), .GAP_TICKS(GAP), .FLAG_HOLD(FH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tele_key(tele_key),
    .kp_key(kp_key), .kp_valid(kp_valid), .kp_bs(kp_bs), .kp_ready(kp_ready),
    .key(key), .flag(flag), .backspace(backspace), .owner(owner), .overrun(overrun)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  // Expected strobe: {is_backspace, key}
  logic [4:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  int strobe_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic       strobe_prev = 1'b0;
  logic       strobe_now;
  int         high_len = 0;
  int         low_len = 0;
  logic [3:0] pulse_key;
  logic [4:0] exp_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      strobe_prev = 1'b0;
      high_len    = 0;
      low_len     = 0;
    end else begin
      if (overrun) ovr_cnt++;
      strobe_now = flag | backspace;
      if (strobe_now && !strobe_prev) begin
        strobe_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got bs=%0d key=%0h expected none", backspace, key);
        end else begin
          exp_e = exp_q.pop_front();
          chk("strobe_code", {27'd0, backspace, key}, {27'd0, exp_e});
        end
        pulse_key = key;
        high_len  = 1;
        low_len   = 0;
      end else if (strobe_now) begin
        high_len++;
      end else if (strobe_prev) begin
        chk("strobe_width", high_len, FH);
        low_len = 1;
      end else if (low_len > 0) begin
        low_len++;
        if (low_len == FH) begin
          chk("key_stable_low", key, pulse_key);
          low_len = 0;
        end
      end
      strobe_prev = strobe_now;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic kp_send(input logic [3:0] code);
    @(negedge clk);
    kp_key   = code;
    kp_valid = 1'b1;
    @(negedge clk);
    kp_valid = 1'b0;
    kp_key   = 4'h0;
  endtask

  task automatic bs_send();
    @(negedge clk);
    kp_bs = 1'b1;
    @(negedge clk);
    kp_bs = 1'b0;
  endtask

  task automatic tele_press(input int len);
    @(negedge clk);
    tele_key = 1'b1;
    repeat (len) @(negedge clk);
    tele_key = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  int before_ovr;
  int before_strobe;
  int n;

  initial begin
    rst_n = 1'b0; en = 1'b1; tele_key = 1'b0;
    kp_key = 4'h0; kp_valid = 1'b0; kp_bs = 1'b0;
    wait_cycles(2);
    chk("rst_key", key, 4'h0);
    chk("rst_flag", flag, 1'b0);
    chk("rst_backspace", backspace, 1'b0);
    chk("rst_owner", owner, 2'b00);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_kp_ready", kp_ready, 1'b1);
    rst_n = 1'b1;
    wait_cycles(3);

    // 1: short press -> dot, auto-commit, owner tele then none
    exp_q.push_back({1'b0, 4'hf});
    exp_q.push_back({1'b0, 4'hd});
    tele_press(10);
    wait_cycles(20);
    chk("t1_owner_tele", owner, 2'b10);
    wait_drain(300);
    chk("t1_owner_none", owner, 2'b00);

    // 2: long press then short press -> dash, dot, commit
    exp_q.push_back({1'b0, 4'he});
    exp_q.push_back({1'b0, 4'hf});
    exp_q.push_back({1'b0, 4'hd});
    tele_press(30);
    wait_cycles(10);
    tele_press(10);
    wait_drain(400);
    chk("t2_owner_none", owner, 2'b00);

    // 3: keypad blocked while tele owns; accepted after commit
    exp_q.push_back({1'b0, 4'hf});
    exp_q.push_back({1'b0, 4'hd});
    tele_press(10);
    wait_cycles(20);
    before_ovr = ovr_cnt;
    before_strobe = strobe_cnt;
    kp_send(4'he);
    wait_cycles(3);
    chk("t3_overrun_nonowner", ovr_cnt - before_ovr, 1);
    chk("t3_no_flag", strobe_cnt - before_strobe, 0);
    wait_drain(300);
    chk("t3_owner_none", owner, 2'b00);
    exp_q.push_back({1'b0, 4'he});
    kp_send(4'he);
    wait_cycles(10);
    chk("t3_owner_kp", owner, 2'b01);
    exp_q.push_back({1'b0, 4'hd});
    kp_send(4'hd);
    wait_drain(100);
    chk("t3_owner_none_after_kp", owner, 2'b00);

    // 4: keypad slot full -> overrun, queued symbol still issued
    exp_q.push_back({1'b0, 4'hf});
    exp_q.push_back({1'b0, 4'he});
    kp_send(4'hf);
    kp_send(4'he);
    chk("t4_kp_ready_low", kp_ready, 1'b0);
    before_ovr = ovr_cnt;
    kp_send(4'he);
    wait_cycles(3);
    chk("t4_overrun_full", ovr_cnt - before_ovr, 1);
    wait_drain(100);
    chk("t4_kp_ready_high", kp_ready, 1'b1);
    exp_q.push_back({1'b0, 4'hd});
    kp_send(4'hd);
    wait_drain(100);
    chk("t4_owner_none", owner, 2'b00);

    // 5: backspace during tele gap, key unchanged, commit still fires
    exp_q.push_back({1'b0, 4'hf});
    tele_press(10);
    wait_cycles(20);
    exp_q.push_back({1'b1, 4'hf});
    exp_q.push_back({1'b0, 4'hd});
    bs_send();
    wait_cycles(8);
    chk("t5_owner_kept", owner, 2'b10);
    wait_drain(300);
    chk("t5_owner_none", owner, 2'b00);

    // 6a: async reset mid S_HIGH
    exp_q.push_back({1'b0, 4'hf});
    kp_send(4'hf);
    n = 0;
    while (!flag && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_flag_seen", flag, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_flag", flag, 1'b0);
    chk("t6_rst_key", key, 4'h0);
    chk("t6_rst_owner", owner, 2'b00);
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(3);

    // 6b: en low mid press -> nothing emitted
    before_strobe = strobe_cnt;
    @(negedge clk);
    tele_key = 1'b1;
    wait_cycles(12);
    en = 1'b0;
    tele_key = 1'b0;
    wait_cycles(3);
    en = 1'b1;
    wait_cycles(100);
    chk("t6_en_no_strobe", strobe_cnt - before_strobe, 0);
    chk("t6_en_owner", owner, 2'b00);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
